mem_bus_arbiter: RTL and testbench

- Shares the single CPU-side port of the memory controller (addr/wdata/rdata/mem_read/mem_write) between two bus masters: m0 = CPU load/store unit, m1 = DMA/blitter.
- Round-robin arbitration, one transaction at a time, registered bus drive, fixed access window of ACCESS_CYCLES cycles, one-cycle ack pulse with read data back to the winning master.
- Sits between the masters and the memory controller; the address map (RAM / keyboard / display) is decoded downstream, not here.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM state
// encoding, master indices and the system memory map bases.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Bit positions of each master in grant/ack/winner vectors
  localparam int unsigned M_CPU = 0;
  localparam int unsigned M_DMA = 1;

  // Memory map bases, decoded downstream by the memory controller
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] KB_BASE   = 32'h2000_0000;
  localparam logic [31:0] DISP_BASE = 32'h3000_0000;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, a tie goes
// to the master that was not served last. Purely combinational.
module rr_pick2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,  // 1 = m1 (DMA) was served last
  output logic [1:0] winner_o       // one-hot, 00 when nobody requests
);

  // Resolve the winner from the request pair and the last owner
  always_comb begin
    winner_o = 2'b00;
    if (req_i == 2'b11) begin
      if (last_grant_i) begin
        winner_o[M_CPU] = 1'b1;
      end else begin
        winner_o[M_DMA] = 1'b1;
      end
    end else begin
      winner_o = req_i;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory controller's single CPU-side port between the CPU
// load/store unit (m0) and the DMA/blitter (m1). One transaction at a time:
// IDLE arbitration, ACCESS_CYCLES of held bus command, one RESP ack cycle.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  // Counter reload: the last ACCESS cycle is the one where cnt reaches zero
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  arb_state_e        state_q;
  logic [3:0]        cnt_q;
  logic              last_grant_q;  // 1 = m1 served last
  logic [1:0]        grant_q;
  logic              busy_q;
  logic              we_q;          // latched direction, survives bus_write drop
  logic              bus_read_q;
  logic              bus_write_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic [1:0]        winner_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d;
  logic [DATA_W-1:0] cap_d;

  rr_pick2 u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .winner_o     (winner_d)
  );

  // Steer the winning master's command toward the bus registers
  always_comb begin
    if (winner_d[M_DMA]) begin
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
      we_d    = m1_we;
    end else begin
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
      we_d    = m0_we;
    end
  end

  // Completion data: memory read data for reads, zero for writes
  always_comb begin
    if (we_q) begin
      cap_d = {DATA_W{1'b0}};
    end else begin
      cap_d = bus_rdata;
    end
  end

  // Arbitration FSM; every bus and master-facing output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
      ack_q        <= 2'b00;
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (winner_d != 2'b00) begin
            bus_addr_q   <= addr_d;
            bus_wdata_q  <= wdata_d;
            we_q         <= we_d;
            bus_read_q   <= ~we_d;
            bus_write_q  <= we_d;
            grant_q      <= winner_d;
            busy_q       <= 1'b1;
            last_grant_q <= winner_d[M_DMA];
            cnt_q        <= CNT_LOAD;
            state_q      <= ARB_ACCESS;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          // Writes strobe for one cycle only so peripherals see a single write
          bus_write_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            bus_read_q  <= 1'b0;
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_wdata_q <= {DATA_W{1'b0}};
            if (grant_q[M_DMA]) begin
              m1_rdata_q <= cap_d;
            end else begin
              m0_rdata_q <= cap_d;
            end
            ack_q   <= grant_q;
            state_q <= ARB_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ARB_RESP: begin
          ack_q   <= 2'b00;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          ack_q       <= 2'b00;
          grant_q     <= 2'b00;
          busy_q      <= 1'b0;
          bus_read_q  <= 1'b0;
          bus_write_q <= 1'b0;
          bus_addr_q  <= {ADDR_W{1'b0}};
          bus_wdata_q <= {DATA_W{1'b0}};
          state_q     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m0_ack    = ack_q[M_CPU];
  assign m1_ack    = ack_q[M_DMA];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with ACCESS_CYCLES=2: reset checks, a table of
// single transactions, hand-written multi-cycle sequences, then randomized
// two-master traffic against a timestamp-based reference model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AC = 2;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_read, bus_write;
  logic [1:0]  grant;
  logic        busy;

  // Memory stand-in: fixed override value or an address-derived word
  logic        rd_ovr_en;
  logic [31:0] rd_ovr_val;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  assign bus_rdata = rd_ovr_en ? rd_ovr_val : mem_word(bus_addr);

  mem_bus_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read),
    .bus_write(bus_write), .bus_rdata(bus_rdata),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic r, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
  endtask

  task automatic drive_req(input int m, input logic r);
    if (m == 0) m0_req = r;
    else m1_req = r;
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_grant"}, grant, 2'b00);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_bus_addr"}, bus_addr, 32'h0);
    chk({p, "_bus_wdata"}, bus_wdata, 32'h0);
    chk({p, "_bus_read"}, bus_read, 1'b0);
    chk({p, "_bus_write"}, bus_write, 1'b0);
    chk({p, "_m0_ack"}, m0_ack, 1'b0);
    chk({p, "_m1_ack"}, m1_ack, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single-transaction table: inputs then expected observations
  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          lat;       // edges from request to visible ack
    int          rd_cyc;    // cycles with bus_read high
    int          wr_cyc;    // cycles with bus_write high
    int          hold_cyc;  // cycles bus_addr/bus_wdata show the command
    int          gnt_cyc;   // cycles grant shows the owner
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [4];

  // Reference model state: transaction start timestamp and latched command
  int          k;
  int          t_start;
  int          last;
  int          own;
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  e_grant, e_ack;
  logic        e_busy, e_read, e_write;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] e_rdata [2];
  logic        pend [2];

  task automatic model_step();
    int d;
    d = k - t_start;
    if (d >= AC + 2 && (m0_req || m1_req)) begin
      if (m0_req && m1_req) own = (last == 1) ? 0 : 1;
      else own = m1_req ? 1 : 0;
      t_we    = (own == 1) ? m1_we : m0_we;
      t_addr  = (own == 1) ? m1_addr : m0_addr;
      t_wdata = (own == 1) ? m1_wdata : m0_wdata;
      last    = own;
      t_start = k;
      d       = 0;
    end
    e_grant = 2'b00; e_busy = 1'b0; e_ack = 2'b00;
    e_addr = 32'h0; e_wdata = 32'h0; e_read = 1'b0; e_write = 1'b0;
    if (d <= AC) begin
      e_grant = (own == 1) ? 2'b10 : 2'b01;
      e_busy  = 1'b1;
    end
    if (d < AC) begin
      e_addr  = t_addr;
      e_wdata = t_wdata;
      e_read  = !t_we;
    end
    e_write = (d == 0) && t_we;
    if (d == AC) begin
      e_ack[own]   = 1'b1;
      e_rdata[own] = t_we ? 32'h0 : mem_word(t_addr);
    end
  endtask

  task automatic new_cmd(input int m);
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0: base = RAM_BASE;
      1: base = KB_BASE;
      default: base = DISP_BASE;
    endcase
    drive(m, 1'b1, ($urandom_range(0, 1) == 1), base + ($urandom_range(0, 255) << 2), $urandom);
    pend[m] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int lat, rdc, wrc, hold, gc, oth, wack, both;
    int t1, t2, cnt_orig, cnt_new, acks;
    logic aw, ao;
    logic [31:0] rv, other_before, orig;
    int q[$];
    int exp_ord [4];

    vt[0] = '{0, 1'b0, RAM_BASE + 32'h10, 32'h5555_AAAA, 32'hDEAD_BEEF, 3, 2, 0, 2, 3, 32'hDEAD_BEEF};
    vt[1] = '{1, 1'b1, DISP_BASE + 32'h4, 32'h0000_00FF, 32'hDEAD_BEEF, 3, 0, 1, 2, 3, 32'h0};
    vt[2] = '{1, 1'b0, KB_BASE, 32'h0F0F_0F0F, 32'h0000_0041, 3, 2, 0, 2, 3, 32'h0000_0041};
    vt[3] = '{0, 1'b1, RAM_BASE + 32'h100, 32'h1234_5678, 32'hCAFE_F00D, 3, 0, 1, 2, 3, 32'h0};
    exp_ord = '{0, 1, 0, 1};

    rd_ovr_en = 1'b0; rd_ovr_val = 32'h0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_m0_rdata", m0_rdata, 32'h0);
    chk("reset_m1_rdata", m1_rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    // Table of single transactions
    for (int i = 0; i < 4; i++) begin
      rd_ovr_en = 1'b1; rd_ovr_val = vt[i].rd;
      other_before = (vt[i].mst == 1) ? m0_rdata : m1_rdata;
      drive(vt[i].mst, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
      lat = -1; rdc = 0; wrc = 0; hold = 0; gc = 0; oth = 0; wack = 0; rv = 32'hFFFF_FFFF;
      for (int c = 1; c <= 12; c++) begin
        tick();
        aw = (vt[i].mst == 1) ? m1_ack : m0_ack;
        ao = (vt[i].mst == 1) ? m0_ack : m1_ack;
        if (bus_read) rdc++;
        if (bus_write) wrc++;
        if (bus_addr == vt[i].addr && bus_wdata == vt[i].wdata) hold++;
        if (grant == ((vt[i].mst == 1) ? 2'b10 : 2'b01)) gc++;
        if (ao) oth++;
        if (aw) begin
          wack++;
          if (lat < 0) begin
            lat = c;
            rv = (vt[i].mst == 1) ? m1_rdata : m0_rdata;
            drive_req(vt[i].mst, 1'b0);
          end
        end
      end
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_read_cycles", i), rdc, vt[i].rd_cyc);
      chk($sformatf("vec%0d_write_cycles", i), wrc, vt[i].wr_cyc);
      chk($sformatf("vec%0d_hold_cycles", i), hold, vt[i].hold_cyc);
      chk($sformatf("vec%0d_grant_cycles", i), gc, vt[i].gnt_cyc);
      chk($sformatf("vec%0d_ack_count", i), wack, 1);
      chk($sformatf("vec%0d_other_ack", i), oth, 0);
      chk($sformatf("vec%0d_rdata", i), rv, vt[i].rdata);
      chk($sformatf("vec%0d_other_rdata", i), (vt[i].mst == 1) ? m0_rdata : m1_rdata, other_before);
    end
    rd_ovr_en = 1'b0;

    // Reset in the middle of a read: outputs drop immediately, no ack later
    drive(0, 1'b1, 1'b0, RAM_BASE + 32'h40, 32'h0);
    tick();
    chk("rstmid_read_active", bus_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rstmid_async");
    drive_req(0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0; gc = 0;
    repeat (6) begin
      tick();
      if (m0_ack || m1_ack) acks++;
      if (grant != 2'b00 || busy) gc++;
    end
    chk("rstmid_no_ack", acks, 0);
    chk("rstmid_idle", gc, 0);
    chk("rstmid_m0_rdata", m0_rdata, 32'h0);

    // Tie from reset with continuous requests: strict alternation
    drive(0, 1'b1, 1'b0, RAM_BASE + 32'h4, 32'h0);
    drive(1, 1'b1, 1'b0, KB_BASE + 32'h8, 32'h0);
    both = 0;
    for (int c = 0; c < 40 && q.size() < 4; c++) begin
      tick();
      if (m0_ack && m1_ack) both++;
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
    end
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
    chk("tie_ack_count", q.size(), 4);
    chk("tie_both_ack", both, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i), (i < q.size()) ? q[i] : 9, exp_ord[i]);
    repeat (3) tick();

    // Command changes and req drop mid-transaction are ignored
    orig = RAM_BASE + 32'h20;
    drive(0, 1'b1, 1'b0, orig, 32'h0);
    cnt_orig = 0; cnt_new = 0; acks = 0; wrc = 0; rv = 32'hFFFF_FFFF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus_addr == orig) cnt_orig++;
      if (bus_addr == KB_BASE) cnt_new++;
      if (bus_write) wrc++;
      if (m0_ack) begin acks++; rv = m0_rdata; end
      if (c == 1) drive(0, 1'b0, 1'b1, KB_BASE, 32'h7777_7777);
    end
    chk("disturb_addr_held", cnt_orig, 2);
    chk("disturb_new_addr", cnt_new, 0);
    chk("disturb_no_write", wrc, 0);
    chk("disturb_ack_once", acks, 1);
    chk("disturb_rdata", rv, mem_word(orig));

    // Back-to-back reads: new command presented on the ack cycle
    drive(0, 1'b1, 1'b0, RAM_BASE + 32'h100, 32'h0);
    t1 = -1; t2 = -1; rv = 32'hFFFF_FFFF;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (m0_ack) begin
        if (t1 < 0) begin
          t1 = c;
          m0_addr = RAM_BASE + 32'h200;
        end else if (t2 < 0) begin
          t2 = c;
          rv = m0_rdata;
          drive_req(0, 1'b0);
        end
      end
    end
    chk("b2b_first_ack", t1, 3);
    chk("b2b_gap", t2 - t1, AC + 2);
    chk("b2b_rdata", rv, mem_word(RAM_BASE + 32'h200));

    // Randomized two-master traffic against the reference model
    do_reset();
    k = 0; t_start = -100; last = 1; own = 0; t_we = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0;
    e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      k++;
      model_step();
      @(negedge clk);
      chk("rnd_grant", grant, e_grant);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_bus_addr", bus_addr, e_addr);
      chk("rnd_bus_wdata", bus_wdata, e_wdata);
      chk("rnd_bus_read", bus_read, e_read);
      chk("rnd_bus_write", bus_write, e_write);
      chk("rnd_m0_ack", m0_ack, e_ack[0]);
      chk("rnd_m1_ack", m1_ack, e_ack[1]);
      chk("rnd_m0_rdata", m0_rdata, e_rdata[0]);
      chk("rnd_m1_rdata", m1_rdata, e_rdata[1]);
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) begin
          if ($urandom_range(0, 1) == 1) new_cmd(m);
          else begin drive_req(m, 1'b0); pend[m] = 1'b0; end
        end else if (pend[m]) begin
          if (own == m && (k - t_start) < AC) begin
            case ($urandom_range(0, 3))
              0: drive(m, (m == 0) ? m0_req : m1_req, ($urandom_range(0, 1) == 1), $urandom, $urandom);
              1: drive_req(m, 1'b0);
              default: ;
            endcase
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_cmd(m);
        end
      end
    end
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
